// File: rtl/score_hud_pkg.sv
// Shared types and helpers for the score HUD: character codes, 8x8 font,
// FSM state encoding and the double-dabble digit adjust.
package score_hud_pkg;

    localparam int unsigned LabelChars = 6;

    typedef enum logic [4:0] {
        ChSpace, ChS, ChC, ChO, ChR, ChE, ChB, ChT,
        Ch0, Ch1, Ch2, Ch3, Ch4, Ch5, Ch6, Ch7, Ch8, Ch9
    } char_e;

    typedef enum logic [1:0] {
        StIdle,
        StConv,
        StCommit
    } state_e;

    function automatic int unsigned pow10(input int unsigned n);
        int unsigned p;
        p = 1;
        for (int unsigned i = 0; i < n; i++) begin
            p = p * 10;
        end
        return p;
    endfunction

    function automatic logic [3:0] dd_adjust(input logic [3:0] n);
        return (n >= 4'd5) ? n + 4'd3 : n;
    endfunction

    function automatic char_e digit_char(input logic [3:0] d);
        return char_e'({1'b0, d} + 5'd8);
    endfunction

    // Six drawn rows per glyph, bit 7 leftmost; rows 6..7 are always blank.
    function automatic logic [7:0] font_row(input char_e c, input logic [2:0] row);
        logic [47:0] g;
        case (c)
            ChS:     g = 48'h78_80_70_08_08_F0;
            ChC:     g = 48'h78_80_80_80_80_78;
            ChO:     g = 48'h70_88_88_88_88_70;
            ChR:     g = 48'hF0_88_F0_A0_90_88;
            ChE:     g = 48'hF8_80_F0_80_80_F8;
            ChB:     g = 48'hF0_88_F0_88_88_F0;
            ChT:     g = 48'hF8_20_20_20_20_20;
            Ch0:     g = 48'h70_88_98_A8_C8_70;
            Ch1:     g = 48'h20_60_20_20_20_70;
            Ch2:     g = 48'h70_88_10_20_40_F8;
            Ch3:     g = 48'hF0_08_70_08_08_F0;
            Ch4:     g = 48'h90_90_F8_10_10_10;
            Ch5:     g = 48'hF8_80_F0_08_08_F0;
            Ch6:     g = 48'h70_80_F0_88_88_70;
            Ch7:     g = 48'hF8_08_10_20_20_20;
            Ch8:     g = 48'h70_88_70_88_88_70;
            Ch9:     g = 48'h70_88_78_08_08_70;
            default: g = 48'h0;
        endcase
        case (row)
            3'd0:    return g[47:40];
            3'd1:    return g[39:32];
            3'd2:    return g[31:24];
            3'd3:    return g[23:16];
            3'd4:    return g[15:8];
            3'd5:    return g[7:0];
            default: return 8'h00;
        endcase
    endfunction

endpackage

// File: rtl/score_hud_bcd.sv
// Iterative double-dabble binary-to-BCD converter: one bit per clock, SCORE_W
// clocks from start to the single-cycle done pulse.
module score_hud_bcd
    import score_hud_pkg::*;
#(
    parameter int unsigned SCORE_W = 10,
    parameter int unsigned DIGITS  = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_start,
    input  logic [SCORE_W-1:0]    i_bin,
    output logic                  o_busy,
    output logic                  o_done,
    output logic [4*DIGITS-1:0]   o_bcd
);

    localparam int unsigned BcdW = 4 * DIGITS;
    localparam int unsigned CntW = $clog2(SCORE_W + 1);

    logic [SCORE_W-1:0] r_bin;
    logic [BcdW-1:0]    r_bcd;
    logic [CntW-1:0]    r_cnt;
    logic               r_busy;
    logic               r_done;
    logic [BcdW-1:0]    w_adj;

    always_comb begin
        w_adj = r_bcd;
        for (int i = 0; i < int'(DIGITS); i++) begin
            w_adj[4*i +: 4] = dd_adjust(r_bcd[4*i +: 4]);
        end
    end

    // The start cycle shifts in the first bit directly; the BCD is zero so no adjust.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bin  <= '0;
            r_bcd  <= '0;
            r_cnt  <= '0;
            r_busy <= 1'b0;
            r_done <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (i_start) begin
                r_bcd  <= BcdW'(i_bin[SCORE_W-1]);
                r_bin  <= i_bin << 1;
                r_cnt  <= CntW'(SCORE_W - 1);
                r_busy <= 1'b1;
            end else if (r_busy) begin
                r_bcd <= {w_adj[BcdW-2:0], r_bin[SCORE_W-1]};
                r_bin <= r_bin << 1;
                r_cnt <= r_cnt - CntW'(1);
                if (r_cnt == CntW'(1)) begin
                    r_busy <= 1'b0;
                    r_done <= 1'b1;
                end
            end
        end
    end

    assign o_busy = r_busy;
    assign o_done = r_done;
    assign o_bcd  = r_bcd;

endmodule

// File: rtl/score_hud.sv
// Frame-synchronous score HUD: per-frame score capture, BCD conversion and a
// registered text-pixel output. Define SCORE_HUD_BEST_EN for the best-score row.
module score_hud
    import score_hud_pkg::*;
#(
    parameter int unsigned SCALE        = 2,
    parameter int unsigned DIGITS       = 3,
    parameter int unsigned SCORE_W      = 10,
    parameter int unsigned X0           = 640 - 8 * (6 + DIGITS) * SCALE - 8,
    parameter int unsigned Y0           = 16,
    parameter int unsigned BLINK_FRAMES = 16,
    parameter logic [11:0] FG           = 12'hFFF,
    parameter logic [11:0] HI_FG        = 12'hFF0
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               i_frame_tick,
    input  logic [SCORE_W-1:0] i_score,
    input  logic               i_clr_best,
    input  logic [9:0]         i_x,
    input  logic [9:0]         i_y,
    output logic               o_on,
    output logic [11:0]        o_rgb
);

    localparam int unsigned NumChars = LabelChars + DIGITS;
    localparam int unsigned CellW    = 8 * SCALE;
    localparam int unsigned BcdW     = 4 * DIGITS;
    localparam int unsigned MaxVal   = pow10(DIGITS) - 1;
    localparam logic [9:0]  XLo      = 10'(X0);
    localparam logic [9:0]  XHi      = 10'(X0 + NumChars * CellW);
    localparam logic [9:0]  Y0Lo     = 10'(Y0);
    localparam logic [9:0]  Y0Hi     = 10'(Y0 + 8 * SCALE);
    localparam logic [9:0]  Y1Lo     = 10'(Y0 + 10 * SCALE);
    localparam logic [9:0]  Y1Hi     = 10'(Y0 + 18 * SCALE);
    localparam logic [9:0]  CellW10  = 10'(CellW);
    localparam logic [9:0]  Scale10  = 10'(SCALE);
    localparam logic [9:0]  Label10  = 10'(LabelChars);

    function automatic logic [DIGITS-1:0] lz_blank(input logic [BcdW-1:0] b);
        logic [DIGITS-1:0] m;
        logic              lead;
        m    = '0;
        lead = 1'b1;
        for (int k = int'(DIGITS) - 1; k > 0; k--) begin
            if (lead && (b[4*k +: 4] == 4'd0)) begin
                m[k] = 1'b1;
            end else begin
                lead = 1'b0;
            end
        end
        return m;
    endfunction

    state_e             r_state;
    logic [SCORE_W-1:0] r_cap;
    logic               r_start;
    logic [BcdW-1:0]    r_disp_bcd;
    logic               r_on;
    logic [11:0]        r_rgb;

    logic [SCORE_W-1:0] w_sat;
    logic               w_done;
    logic               w_unused_busy;
    logic [BcdW-1:0]    w_bcd;
    logic               w_commit;

    assign w_sat    = (32'(i_score) > MaxVal) ? SCORE_W'(MaxVal) : i_score;
    assign w_commit = (r_state == StCommit);

    score_hud_bcd #(
        .SCORE_W (SCORE_W),
        .DIGITS  (DIGITS)
    ) u_bcd (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_start (r_start),
        .i_bin   (r_cap),
        .o_busy  (w_unused_busy),
        .o_done  (w_done),
        .o_bcd   (w_bcd)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= StIdle;
            r_cap      <= '0;
            r_start    <= 1'b0;
            r_disp_bcd <= '0;
        end else begin
            r_start <= 1'b0;
            unique case (r_state)
                StIdle: begin
                    if (i_frame_tick) begin
                        r_cap   <= w_sat;
                        r_start <= 1'b1;
                        r_state <= StConv;
                    end
                end
                StConv: begin
                    if (w_done) begin
                        r_state <= StCommit;
                    end
                end
                StCommit: begin
                    r_disp_bcd <= w_bcd;
                    r_state    <= StIdle;
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    logic [BcdW-1:0] w_best_bcd;
    logic            w_blink_on;
    logic            w_hide;
    logic            w_best_row_en;

`ifdef SCORE_HUD_BEST_EN
    logic [SCORE_W-1:0] r_best_bin;
    logic [BcdW-1:0]    r_best_bcd;
    logic [7:0]         r_blink_cnt;

    // A clear in the commit cycle wins over recording a new best.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_best_bin  <= '0;
            r_best_bcd  <= '0;
            r_blink_cnt <= '0;
        end else if (i_clr_best) begin
            r_best_bin  <= '0;
            r_best_bcd  <= '0;
            r_blink_cnt <= '0;
        end else if (w_commit && (r_cap > r_best_bin)) begin
            r_best_bin  <= r_cap;
            r_best_bcd  <= w_bcd;
            r_blink_cnt <= 8'(BLINK_FRAMES);
        end else if (i_frame_tick && (r_blink_cnt != 8'd0)) begin
            r_blink_cnt <= r_blink_cnt - 8'd1;
        end
    end

    assign w_best_bcd    = r_best_bcd;
    assign w_blink_on    = (r_blink_cnt != 8'd0);
    assign w_hide        = w_blink_on && r_blink_cnt[1];
    assign w_best_row_en = 1'b1;
`else
    logic w_unused_clr;

    assign w_unused_clr  = i_clr_best;
    assign w_best_bcd    = '0;
    assign w_blink_on    = 1'b0;
    assign w_hide        = 1'b0;
    assign w_best_row_en = 1'b0;
`endif

    logic [DIGITS-1:0] w_disp_blank;
    logic [DIGITS-1:0] w_best_blank;

    assign w_disp_blank = lz_blank(r_disp_bcd);
    assign w_best_blank = lz_blank(w_best_bcd);

    logic [9:0]        w_dx;
    logic [9:0]        w_dy;
    logic [9:0]        w_char;
    logic [9:0]        w_pos;
    logic [2:0]        w_col;
    logic [2:0]        w_frow;
    logic              w_in_x;
    logic              w_row0;
    logic              w_row1;
    logic [BcdW-1:0]   w_row_bcd;
    logic [DIGITS-1:0] w_row_blank;
    logic [3:0]        w_nib;
    logic              w_lz;
    char_e             w_label;
    char_e             w_glyph_char;
    logic [7:0]        w_glyph;
    logic              w_on;
    logic [11:0]       w_colour;

    always_comb begin
        w_dx        = i_x - XLo;
        w_char      = w_dx / CellW10;
        w_col       = 3'((w_dx % CellW10) / Scale10);
        w_in_x      = (i_x >= XLo) && (i_x < XHi);
        w_row0      = w_in_x && (i_y >= Y0Lo) && (i_y < Y0Hi);
        w_row1      = w_best_row_en && w_in_x && (i_y >= Y1Lo) && (i_y < Y1Hi);
        w_dy        = w_row1 ? (i_y - Y1Lo) : (i_y - Y0Lo);
        w_frow      = 3'(w_dy / Scale10);
        w_row_bcd   = w_row1 ? w_best_bcd : r_disp_bcd;
        w_row_blank = w_row1 ? w_best_blank : w_disp_blank;

        // Digit cells run most-significant first, so cell LabelChars is nibble DIGITS-1.
        w_pos = w_char - Label10;
        w_nib = 4'd0;
        w_lz  = 1'b0;
        for (int k = 0; k < int'(DIGITS); k++) begin
            if (w_pos == 10'(int'(DIGITS) - 1 - k)) begin
                w_nib = w_row_bcd[4*k +: 4];
                w_lz  = w_row_blank[k];
            end
        end

        w_label = ChSpace;
        if (w_row1) begin
            case (w_char[2:0])
                3'd0:    w_label = ChB;
                3'd1:    w_label = ChE;
                3'd2:    w_label = ChS;
                3'd3:    w_label = ChT;
                default: w_label = ChSpace;
            endcase
        end else begin
            case (w_char[2:0])
                3'd0:    w_label = ChS;
                3'd1:    w_label = ChC;
                3'd2:    w_label = ChO;
                3'd3:    w_label = ChR;
                3'd4:    w_label = ChE;
                default: w_label = ChSpace;
            endcase
        end

        if (w_char < Label10) begin
            w_glyph_char = w_label;
        end else if (w_lz || (w_row1 && w_hide)) begin
            w_glyph_char = ChSpace;
        end else begin
            w_glyph_char = digit_char(w_nib);
        end

        w_glyph  = font_row(w_glyph_char, w_frow);
        w_on     = (w_row0 || w_row1) && w_glyph[3'd7 - w_col];
        w_colour = (w_row1 && w_blink_on) ? HI_FG : FG;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_on  <= 1'b0;
            r_rgb <= 12'h000;
        end else begin
            r_on  <= w_on;
            r_rgb <= w_on ? w_colour : 12'h000;
        end
    end

    assign o_on  = r_on;
    assign o_rgb = r_rgb;

endmodule

// File: tb/tb_score_hud.sv
// Directed bench for score_hud: glyph signatures of digit cells, conversion
// latency, saturation, blink, clear-best and mid-conversion reset.
module tb_score_hud;

    localparam int unsigned SCALE   = 2;
    localparam int unsigned DIGITS  = 3;
    localparam int unsigned SCORE_W = 10;
    localparam int          XBASE   = 488;
    localparam int          YROW0   = 16;
    localparam int          YROW1   = 36;
    localparam int          CELL    = 16;

`ifdef SCORE_HUD_BEST_EN
    localparam bit BestEn = 1'b1;
`else
    localparam bit BestEn = 1'b0;
`endif

    logic               clk        = 1'b0;
    logic               rst_n      = 1'b0;
    logic               frame_tick = 1'b0;
    logic               clr_best   = 1'b0;
    logic [SCORE_W-1:0] score      = '0;
    logic [9:0]         x          = '0;
    logic [9:0]         y          = '0;
    logic               on;
    logic [11:0]        rgb;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    score_hud #(
        .SCALE   (SCALE),
        .DIGITS  (DIGITS),
        .SCORE_W (SCORE_W)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_frame_tick (frame_tick),
        .i_score      (score),
        .i_clr_best   (clr_best),
        .i_x          (x),
        .i_y          (y),
        .o_on         (on),
        .o_rgb        (rgb)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // {font row 0, font row 2} of each digit glyph
    function automatic logic [15:0] digit_sig(input int d);
        case (d)
            0:       return 16'h7098;
            1:       return 16'h2020;
            2:       return 16'h7010;
            3:       return 16'hF070;
            4:       return 16'h90F8;
            5:       return 16'hF8F0;
            6:       return 16'h70F0;
            7:       return 16'hF810;
            8:       return 16'h7070;
            9:       return 16'h7078;
            default: return 16'h0000;
        endcase
    endfunction

    task automatic probe(input int px, input int py, output logic p_on, output logic [11:0] p_rgb);
        @(negedge clk);
        x = 10'(px);
        y = 10'(py);
        @(posedge clk);
        #1;
        p_on  = on;
        p_rgb = rgb;
    endtask

    task automatic cell_sig(input int row, input int ci, output logic [15:0] sig,
                            output logic [11:0] col);
        logic        o;
        logic [11:0] c;
        sig = '0;
        col = '0;
        for (int fr = 0; fr < 2; fr++) begin
            for (int cc = 0; cc < 8; cc++) begin
                probe(XBASE + ci * CELL + cc * int'(SCALE),
                      (row == 1 ? YROW1 : YROW0) + fr * 2 * int'(SCALE), o, c);
                sig[15 - fr * 8 - cc] = o;
                if (o) col = c;
            end
        end
    endtask

    // Digit value -1 means the cell must be empty.
    task automatic check_row(input string tag, input int row, input int h, input int t,
                             input int o, input logic [11:0] ecol);
        int          d[3];
        logic [15:0] s;
        logic [15:0] e;
        logic [11:0] c;
        logic [11:0] call;
        d[0] = h;
        d[1] = t;
        d[2] = o;
        call = '0;
        for (int i = 0; i < 3; i++) begin
            cell_sig(row, 6 + i, s, c);
            e = (d[i] < 0) ? 16'h0 : digit_sig(d[i]);
            if (row == 1 && !BestEn) e = 16'h0;
            check_eq($sformatf("%s_d%0d", tag, i), 32'(s), 32'(e));
            if (c != 12'h0) call = c;
        end
        check_eq($sformatf("%s_rgb", tag), 32'(call),
                 32'((row == 1 && !BestEn) ? 12'h000 : ecol));
    endtask

    task automatic tick(input int sc);
        @(negedge clk);
        score      = SCORE_W'(sc);
        frame_tick = 1'b1;
        @(negedge clk);
        frame_tick = 1'b0;
        repeat (SCORE_W + 4) @(negedge clk);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] s;
        logic [11:0] c;
        logic        o;
        logic [11:0] r;
        int          any_on;

        repeat (3) @(negedge clk);
        check_eq("rst_on", 32'(on), 32'(0));
        check_eq("rst_rgb", 32'(rgb), 32'(0));
        rst_n = 1'b1;

        check_row("rst_r0", 0, -1, -1, 0, 12'hFFF);
        check_row("rst_r1", 1, -1, -1, 0, 12'hFFF);
        cell_sig(0, 0, s, c);
        check_eq("lbl_r0", 32'(s), 32'(16'h7870));
        check_eq("lbl_r0_rgb", 32'(c), 32'(12'hFFF));

        // Ones cell col 0 of font row 0: off for '0', on for '3'.
        @(negedge clk);
        x          = 10'(XBASE + 8 * CELL);
        y          = 10'(YROW0);
        score      = 10'd123;
        frame_tick = 1'b1;
        @(posedge clk);
        #1;
        @(negedge clk);
        frame_tick = 1'b0;
        for (int e = 1; e <= 13; e++) begin
            @(posedge clk);
            #1;
            if (e == 12) check_eq("lat_pre", 32'(on), 32'(0));
            if (e == 13) check_eq("lat_post", 32'(on), 32'(1));
        end
        check_row("s123_r0", 0, 1, 2, 3, 12'hFFF);
        check_row("s123_r1", 1, 1, 2, 3, 12'hFF0);

        repeat (2) tick(123);
        check_row("blk_hide", 1, -1, -1, -1, 12'h000);
        cell_sig(1, 0, s, c);
        check_eq("blk_lbl", 32'(s), 32'(BestEn ? 16'hF0F0 : 16'h0));
        check_eq("blk_lbl_rgb", 32'(c), 32'(BestEn ? 12'hFF0 : 12'h000));
        repeat (13) tick(123);
        check_row("blk_last", 1, 1, 2, 3, 12'hFF0);
        tick(123);
        check_row("blk_done", 1, 1, 2, 3, 12'hFFF);

        tick(1023);
        check_row("sat_r0", 0, 9, 9, 9, 12'hFFF);
        check_row("sat_r1", 1, 9, 9, 9, 12'hFF0);
        repeat (16) tick(5);
        check_row("five_r0", 0, -1, -1, 5, 12'hFFF);
        check_row("five_r1", 1, 9, 9, 9, 12'hFFF);

        // Second tick lands on the third CONV cycle and must be ignored.
        @(negedge clk);
        score      = 10'd42;
        frame_tick = 1'b1;
        @(negedge clk);
        frame_tick = 1'b0;
        @(negedge clk);
        @(negedge clk);
        score      = 10'd77;
        frame_tick = 1'b1;
        @(negedge clk);
        frame_tick = 1'b0;
        repeat (SCORE_W + 4) @(negedge clk);
        check_row("ign_r0", 0, -1, 4, 2, 12'hFFF);

        @(negedge clk);
        clr_best = 1'b1;
        @(negedge clk);
        clr_best = 1'b0;
        check_row("clr_r1", 1, -1, -1, 0, 12'hFFF);

        // Clear coincides with the commit edge (SCORE_W+2 after the tick edge).
        @(negedge clk);
        score      = 10'd200;
        frame_tick = 1'b1;
        @(negedge clk);
        frame_tick = 1'b0;
        repeat (SCORE_W + 1) @(negedge clk);
        clr_best = 1'b1;
        @(negedge clk);
        clr_best = 1'b0;
        repeat (2) @(negedge clk);
        check_row("clrc_r0", 0, 2, 0, 0, 12'hFFF);
        check_row("clrc_r1", 1, -1, -1, 0, 12'hFFF);
        tick(200);
        check_row("clr_new", 1, 2, 0, 0, 12'hFF0);

        probe(XBASE + 8 * CELL + int'(SCALE), YROW0, o, r);
        check_eq("pre_rst_on", 32'(o), 32'(1));
        @(negedge clk);
        score      = 10'd321;
        frame_tick = 1'b1;
        @(negedge clk);
        frame_tick = 1'b0;
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_eq("mid_rst_on", 32'(on), 32'(0));
        check_eq("mid_rst_rgb", 32'(rgb), 32'(0));
        @(negedge clk);
        rst_n = 1'b1;
        repeat (SCORE_W + 4) @(negedge clk);
        check_row("mrst_r0", 0, -1, -1, 0, 12'hFFF);
        check_row("mrst_r1", 1, -1, -1, 0, 12'hFFF);

        any_on = 0;
        for (int yy = YROW1; yy < YROW1 + 16; yy++) begin
            for (int xx = XBASE; xx < XBASE + 9 * CELL; xx++) begin
                probe(xx, yy, o, r);
                if (o) any_on++;
            end
        end
        check_eq("row1_sweep", 32'(any_on != 0), 32'(BestEn));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/score_hud.md
# score_hud

Frame-synchronous, parametrised heads-up score display for the 640x480 VGA pipeline. It samples the game score once per frame and converts it to BCD with an iterative double-dabble sub-block. It tracks a best score and renders one or two scaled 8x8-font text rows ("SCORE nnn" / "BEST  nnn") with a registered pixel output. It sits beside the sprite/pipe renderers and feeds the top-level pixel mux.

## Interface
- SCALE, 2: font pixel scale factor (1..4).
- DIGITS, 3: displayed decimal digits (1..5).
- SCORE_W, 10: score input width (4..17).
- X0, 640-8*(6+DIGITS)*SCALE-8: left edge of the text block.
- Y0, 16: top edge of row 0.
- BLINK_FRAMES, 16: frames the best row blinks after a new best (1..255).
- FG, 12'hFFF: normal text colour.
- HI_FG, 12'hFF0: best-row colour while blinking.

Ports:
- clk  in  1  pixel clock.
- rst_n  in  1  reset. One clock; reset is asynchronous and active-low.
- frame_tick  in  1  one-cycle pulse per frame, at start of vertical blank.
- score  in  SCORE_W  current score, unsigned.
- clr_best  in  1  synchronous clear of the best score.
- x, y  in  10 each  current pixel coordinate.
- on  out  1  pixel belongs to text (registered).
- rgb  out  12  text colour (registered); 12'h000 when on=0.

## Operation
- Saturation: captured value = min(score, 10^DIGITS-1). Conversion operates on the saturated value only.
- FSM states:
  - IDLE: on frame_tick, capture the saturated score, pulse start to the converter, go to CONV.
  - CONV: wait for the converter's done, then go to COMMIT.
  - COMMIT: write score_bcd into disp_bcd. If saturated value > best_bin, also set best_bin and best_bcd and load blink_cnt=BLINK_FRAMES. Return to IDLE.
- frame_tick while not in IDLE is ignored.
- Blink:
  - blink_cnt decrements on each frame_tick while nonzero.
  - While nonzero, the best row uses HI_FG, and its digits are hidden when blink_cnt[1]=1.
  - Labels always stay visible.
- clr_best: zeroes best_bin, best_bcd and blink_cnt. If clr_best coincides with COMMIT, the clear wins and no new best is recorded that frame.
- Rendering:
  - Row 0 is "SCORE " followed by DIGITS digits. Row 1 is "BEST  " followed by DIGITS digits.
  - NUM_CHARS = 6+DIGITS; each character cell is 8*SCALE wide.
  - Row 1 top = Y0 + 10*SCALE.
  - Leading-zero blanking applies; the ones digit is always drawn.
  - Glyph bit 7 is the leftmost pixel. Font rows 6..7 are blank.

## Timing
- Reset values: on=0, rgb=0, state=IDLE. disp_bcd, best_bcd, best_bin and blink_cnt are all 0, so each row shows "0".
- Pixel path: exactly 1 cycle from x/y to on/rgb, with no bubbles.
- Conversion latency: the converter takes SCORE_W cycles. disp_bcd updates on the (SCORE_W+2)th rising edge after the edge that samples frame_tick.
- Display registers change only in COMMIT. A frame never mixes digits from two scores (frame_tick is asserted in blanking).
- Reset mid-conversion: everything returns to reset values immediately, and the partial result is discarded.
- Simultaneous frame_tick and COMMIT cannot occur; a frame_tick arriving in any non-IDLE state is ignored.
- blink_cnt decrements on frame_tick in any FSM state.

## Configuration
- SCORE_HUD_BEST_EN defined: best tracking, row 1, blink and clr_best are all present.
- Not defined:
  - Only row 0 is rendered; pixels in the row-1 area give on=0.
  - clr_best is ignored, and the best registers and blink logic are not generated.
  - Port list is unchanged.

## Structure
- Package score_hud_pkg holds:
  - the char-code enum (space, A-Z subset S C O R E B T, digits 0-9);
  - the font_row(char, row) function;
  - the FSM state typedef.
- Sub-module score_hud_bcd: iterative double-dabble converter with parameters SCORE_W and DIGITS.
  - Ports: clk, rst_n, start, bin, busy, done, bcd[4*DIGITS].
  - done is a one-cycle pulse.
- The top level contains the FSM, best/blink registers and the pixel pipeline.

## Test plan
- Reset with x=X0,y=Y0 sweep: ones-digit cells of both rows render glyph "0" in FG. All other digit cells give on=0.
- score=123, one frame_tick: after SCORE_W+2 cycles, row 0 shows "123" and row 1 shows "123" in HI_FG with blink, blink_cnt=16. After 16 frame_ticks, row 1 shows FG steadily.
- score=1023 (SCORE_W=10, DIGITS=3): display saturates to "999". Then score=5 gives row 0 "  5" and row 1 stays "999", with no blink retriggered.
- Second frame_tick at cycle 3 of CONV: ignored. Only one COMMIT occurs and disp_bcd reflects the first capture.
- clr_best asserted in the COMMIT cycle with score=200>best: best_bin=0 and no blink. The next frame with score=200 sets best to 200.
- Build without SCORE_HUD_BEST_EN, sweep the row-1 area: on=0 everywhere. Row 0 behaviour is identical to the first two scenarios.
